// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// All outputs are registered; tx_out idles high.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          push, pop, baud_last, load_par;
    logic [7:0]    head;

    assign push      = tx_valid & ready_q;
    assign head      = mem_q[rd_ptr_q];
    assign load_par  = (^head) ^ (PARITY_ODD != 0);
    assign baud_last = (baud_q == BAUD_LAST);

    assign tx_out     = tx_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = load_par;
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // shift_q[0] is the bit on the line, so the next one is [1]
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = load_par;
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ready_d  = (count_d != FULL);
        busy_d   = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the UART module: 8-bit byte serializer whose serial output drives the `rx` block's `rx_in`.
- Accepts bytes on a valid/ready handshake into a small FIFO.
- Emits asynchronous frames of 1 start bit, 8 data bits LSB-first, an optional parity bit and 1 or 2 stop bits.
- Defaults match the system point: 50 MHz clock, 115200 baud.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200).
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2 and ≥2.

Ports:
- clock, input, 1: single system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- tx_data, input, 8: byte to transmit.
- tx_valid, input, 1: tx_data valid this cycle.
- tx_ready, output, 1: FIFO can accept; transfer occurs on an edge where tx_valid & tx_ready.
- tx_out, output, 1: serial line, idle high; connects to rx_in.
- busy, output, 1: 1 while a frame is in progress or the FIFO is non-empty.
- fifo_count, output, clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset (synchronous, wins over everything):
  - tx_out=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM=IDLE; baud and bit counters=0; FIFO pointers=0, contents discarded.
  - Reset mid-frame aborts the frame: tx_out is 1 after the reset edge and no resumption occurs.
- Registered outputs: tx_out, tx_ready and busy are registered; no combinational path from inputs to outputs.
- FIFO:
  - tx_ready = (fifo_count != FIFO_DEPTH), registered.
  - A push while full cannot occur; a pop in the same cycle does not enable a push (no full bypass).
  - Simultaneous push and pop when non-full: fifo_count unchanged, pointers wrap modulo FIFO_DEPTH.
  - No empty bypass: a byte pushed into an empty FIFO is popped on the following edge at the earliest.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. If fifo_count>0, pop the head into the shift register, go to START, drive tx_out=0, baud counter=0.
    - Latency: push accepted at edge N into an idle, empty block → tx_out falls at edge N+1.
  - Every bit state holds tx_out for exactly CLKS_PER_BIT clocks. The baud counter counts 0..CLKS_PER_BIT-1; the terminal count advances the state.
  - START → DATA: tx_out=shift[0].
  - DATA: 8 bits LSB-first; bit counter 0..7; shift right each bit.
    - After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_out = (^byte) ^ PARITY_ODD, computed from the byte as popped.
  - STOP: tx_out=1 for STOP_BITS×CLKS_PER_BIT clocks.
    - At terminal count, if fifo_count>0, pop and enter START directly with tx_out=0 on the same edge (zero idle gap). Otherwise go to IDLE.
- Frame length: (10 + PARITY_EN + STOP_BITS − 1) × CLKS_PER_BIT clocks; default 4340.
- busy: 1 from the edge after acceptance until the edge where STOP ends with an empty FIFO.
- tx_data is sampled only at the accept edge; later changes have no effect on queued bytes.

Test Plan:
- Default params, reset then push 0xAA:
  - tx_out falls 1 clock after accept.
  - Then 434-cycle bits 0,0,1,0,1,0,1,0,1,1 (start, LSB-first data, stop).
  - busy=1 for exactly 4341 cycles from accept.
  - With tx_out looped into `rx`: Rx=8'hAA, error=0.
- PARITY_EN=1, PARITY_ODD=0:
  - Push 0x55 → parity bit 0.
  - Push 0x01 → parity bit 1.
  - Frame is 11×434 cycles.
  - With PARITY_ODD=1, both parity bits invert.
- Back-to-back with FIFO_DEPTH=4: push 6 bytes 0x10..0x15 with tx_valid held high.
  - Bytes 0x10..0x14 accepted on 5 consecutive edges; tx_ready=0 with fifo_count=4 afterwards.
  - 0x15 accepted the edge after 0x11 is popped at the end of frame 1.
  - Six frames with no idle gap between stop and next start.
- Reset asserted at cycle 2000 of a frame with 3 bytes queued:
  - tx_out=1, fifo_count=0, busy=0, tx_ready=1 after the reset edge.
  - No further frames.
- STOP_BITS=2: push 0xFF → tx_out low for only the 434-cycle start bit, then high for 8×434 + 2×434 cycles. The next queued byte's start bit begins exactly at cycle 4774.
- Idle stability: no pushes for 10000 cycles after reset → tx_out=1, busy=0, fifo_count=0 throughout.
